// File: rtl/instr_prefetch.sv
// Instruction prefetch: two-word fetch (instr @pc, imm @pc+1) into a small FIFO for decode.
// Optional PREFETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module instr_prefetch #(
  parameter int              WORD     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [WORD-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_pc,
  output logic [WORD-1:0] out_instr,
  output logic [WORD-1:0] out_imm,
`ifdef PREFETCH_STATS_EN
  output logic [WORD-1:0] stat_fetched,
  output logic [WORD-1:0] stat_flushed,
`endif
  output logic            full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_INSTR, S_IMM, S_WAIT} state_t;
  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
    logic [WORD-1:0] imm;
  } entry_t;

  state_t          state, state_nx;
  logic            run;
  logic [WORD-1:0] fetch_pc, fetch_pc_nx;
  logic [WORD-1:0] redir_pc, redir_pc_nx;
  logic [WORD-1:0] instr_q;
  logic            discard, discard_nx;
  logic            push, pop, flush, latch_instr, ack_ok;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  entry_t          head;

  // run holds mem_req low for the first cycle after reset release
  assign mem_req   = run & ((state == S_INSTR) | (state == S_IMM));
  assign mem_addr  = (state == S_IMM) ? fetch_pc + WORD'(1) : fetch_pc;
  assign ack_ok    = mem_req & mem_ack;
  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid & out_ready;
  assign head      = fifo[rd_ptr];
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_imm   = head.imm;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    redir_pc_nx = redir_pc;
    discard_nx  = discard;
    push        = 1'b0;
    latch_instr = 1'b0;
    flush       = redirect;
    if (discard) begin
      // abandoned request still in flight: hold bus until its ack, then drop the data
      if (redirect) redir_pc_nx = redirect_addr;
      if (ack_ok) begin
        discard_nx  = 1'b0;
        fetch_pc_nx = redirect ? redirect_addr : redir_pc;
        state_nx    = S_INSTR;
      end
    end else if (redirect) begin
      if (mem_req && !mem_ack) begin
        discard_nx  = 1'b1;
        redir_pc_nx = redirect_addr;
      end else begin
        fetch_pc_nx = redirect_addr;
        state_nx    = S_INSTR;
      end
    end else begin
      case (state)
        S_INSTR: if (ack_ok) begin
          latch_instr = 1'b1;
          state_nx    = S_IMM;
        end
        S_IMM: if (ack_ok) begin
          push        = 1'b1;
          fetch_pc_nx = fetch_pc + WORD'(2);
          state_nx    = ((count - (AW+1)'(pop)) == FULL_CNT - 1'b1) ? S_WAIT : S_INSTR;
        end
        S_WAIT: if (pop) state_nx = S_INSTR;
        default: state_nx = S_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INSTR;
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      redir_pc <= '0;
      instr_q  <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      run      <= 1'b1;
      fetch_pc <= fetch_pc_nx;
      redir_pc <= redir_pc_nx;
      discard  <= discard_nx;
      if (latch_instr) instr_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{pc: fetch_pc, instr: instr_q, imm: mem_rdata};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [AW:0]   flush_cnt;
  logic [WORD:0] fetched_sum, flushed_sum;

  assign flush_cnt   = redirect ? (count - (AW+1)'(pop)) : '0;
  assign fetched_sum = {1'b0, stat_fetched} + (WORD+1)'(push);
  assign flushed_sum = {1'b0, stat_flushed} + (WORD+1)'(flush_cnt) + (WORD+1)'(discard & ack_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= fetched_sum[WORD] ? '1 : fetched_sum[WORD-1:0];
      stat_flushed <= flushed_sum[WORD] ? '1 : flushed_sum[WORD-1:0];
      if (redirect) $display("instr_prefetch: redirect to %h, %0d entries flushed", redirect_addr, flush_cnt);
    end
  end
`endif

endmodule
